wb_ram_arbiter: RTL and testbench
=================================

Name: wb_ram_arbiter

Overview:
- Two-port Wishbone arbiter that shares one single-port, byte-enabled 32-bit RAM between an instruction bus (read-only) and a data bus (read/write).
- Grants one requester at a time with round-robin priority.
- Registers the granted command toward the RAM and generates per-master acks aligned to the RAM's one-cycle registered read.
- Sits between the CPU bus masters and the RAM instance.

Parameters:
- depth, 256, RAM size in bytes; must match the attached RAM.
- aw, $clog2(depth), byte-address width.

Ports:
- i_wb_clk  in  1  system clock; all logic on its rising edge.
- i_wb_rst  in  1  synchronous, active-high reset.
- i_ibus_adr  in  aw  instruction byte address.
- i_ibus_cyc  in  1  instruction request.
- o_ibus_rdt  out  32  instruction read data.
- o_ibus_ack  out  1  instruction ack, one-cycle pulse.
- i_dbus_adr  in  aw  data byte address.
- i_dbus_dat  in  32  write data.
- i_dbus_sel  in  4  byte enables.
- i_dbus_we  in  1  write enable.
- i_dbus_cyc  in  1  data request.
- o_dbus_rdt  out  32  data read data.
- o_dbus_ack  out  1  data ack, one-cycle pulse.
- o_ram_adr  out  aw  RAM address.
- o_ram_dat  out  32  RAM write data.
- o_ram_sel  out  4  RAM byte enables.
- o_ram_we  out  1  RAM write enable.
- o_ram_cyc  out  1  RAM cycle.
- i_ram_rdt  in  32  RAM read data, valid one cycle after the command edge.

Behaviour:
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Any cyc high: pick the grantee, latch its command into the o_ram_* registers, go to ACCESS.
- ACCESS: o_ram_cyc=1 for exactly one cycle; the RAM samples the command at the closing edge; go to ACK.
- ACK: assert the grantee's ack (registered, one cycle only); go to IDLE.
- Latency: request seen in IDLE at cycle N → ack high in cycle N+2 → next grant possible in cycle N+3. Throughput is one access per 3 cycles.
- Command latching for ibus grant: o_ram_adr=i_ibus_adr, o_ram_we=0, o_ram_sel=4'hF, o_ram_dat=0.
- Command latching for dbus grant: all dbus fields copied unchanged.
- Write gating: o_ram_we is forced 0 outside ACCESS, so each write occurs exactly once.
- Arbitration:
  - A 1-bit last_grant register holds the most recent grantee.
  - Single requester: it is granted.
  - Both requesting: the one that is NOT last_grant wins.
  - last_grant updates on every grant.
- Fairness: a continuously requesting master is acked within 6 cycles of raising cyc.
- Read data:
  - o_ibus_rdt and o_dbus_rdt are both combinational copies of i_ram_rdt.
  - Valid only while the matching ack is high; masters ignore them otherwise.
  - A dbus write still acks; its rdt is don't-care.
- Master drops cyc during ACCESS or ACK (protocol violation): the access completes and the ack still pulses. No abort.
- Simultaneous requests on the first cycle after reset: ibus wins (last_grant resets to dbus).
- Address handling: full byte address passes through; word selection happens in the RAM.
- Reset (synchronous; applies even mid-ACCESS/ACK; the RAM command is dropped from the next cycle):
  - State → IDLE.
  - o_ram_cyc, o_ram_we, o_ram_sel → 0.
  - o_ram_adr, o_ram_dat → 0.
  - Both acks → 0.
  - last_grant → dbus.
  - A write whose ACCESS cycle coincides with the reset cycle still reaches the RAM that edge; software must not depend on it.
- Invariants:
  - Never both acks in the same cycle.
  - Never an ack without a preceding ACCESS cycle.

Test Plan:
- Single ibus read: preload word 0x10 = 0xDEADBEEF; ibus_cyc=1, adr=0x40 at cycle 0 → o_ram_cyc=1 in cycle 1 only; o_ibus_ack=1 in cycle 2 with o_ibus_rdt=0xDEADBEEF; o_dbus_ack stays 0.
- Byte-enable write then read: dbus write adr=0x08, dat=0x11223344, sel=4'b0101 over a word holding 0xAAAAAAAA → ack at cycle 2; a dbus read of 0x08 then returns 0xAA22AA44.
- Contention: both cyc held high from the first cycle after reset → acks alternate ibus, dbus, ibus, dbus at cycles 2, 5, 8, 11.
- Back-to-back single master: ibus issues 4 reads of 0x00/0x04/0x08/0x0C, raising each new cyc the cycle after the previous ack → acks at cycles 2, 5, 8, 11 with matching data.
- Reset mid-operation: dbus write granted, i_wb_rst=1 in the ACK cycle → o_dbus_ack=0 that cycle onward after the edge, state IDLE, o_ram_cyc=0. The next simultaneous request after reset grants ibus first.
- cyc withdrawal: dbus drops cyc during ACCESS → o_dbus_ack still pulses once in the next cycle; no second access occurs.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter sharing one byte-enabled single-port RAM between an ibus (read) and a dbus (read/write).
// Three-cycle access (grant, RAM cycle, ack); a requester simply waits in cyc until its ack pulses.
module wb_ram_arbiter #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [aw-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [aw-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [aw-1:0] o_ram_adr,
  output logic [31:0]   o_ram_dat,
  output logic [3:0]    o_ram_sel,
  output logic          o_ram_we,
  output logic          o_ram_cyc,
  input  logic [31:0]   i_ram_rdt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // 1 = dbus; during ACCESS/ACK this also names the current grantee
  logic last_grant;
  logic grant_vld;
  logic grant_dbus;

  always_comb begin
    grant_vld  = i_ibus_cyc | i_dbus_cyc;
    grant_dbus = 1'b0;
    if (i_ibus_cyc && i_dbus_cyc) begin
      grant_dbus = ~last_grant;
    end else begin
      grant_dbus = i_dbus_cyc;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command strobes are cleared every cycle so cyc/we are high only during ACCESS
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      o_ram_adr  <= '0;
      o_ram_dat  <= '0;
      o_ram_sel  <= '0;
      o_ram_we   <= 1'b0;
      o_ram_cyc  <= 1'b0;
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      o_ram_we   <= 1'b0;
      o_ram_cyc  <= 1'b0;
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant <= grant_dbus;
            o_ram_cyc  <= 1'b1;
            if (grant_dbus) begin
              o_ram_adr <= i_dbus_adr;
              o_ram_dat <= i_dbus_dat;
              o_ram_sel <= i_dbus_sel;
              o_ram_we  <= i_dbus_we;
            end else begin
              o_ram_adr <= i_ibus_adr;
              o_ram_dat <= '0;
              o_ram_sel <= 4'hF;
              o_ram_we  <= 1'b0;
            end
          end
        end
        ACCESS: begin
          o_ibus_ack <= ~last_grant;
          o_dbus_ack <= last_grant;
        end
        default: ;
      endcase
    end
  end

  assign o_ibus_rdt = i_ram_rdt;
  assign o_dbus_rdt = i_ram_rdt;

  a_one_ack: assert property (@(posedge i_wb_clk) !(o_ibus_ack && o_dbus_ack));
  a_ack_after_access: assert property (@(posedge i_wb_clk) disable iff (i_wb_rst)
    (o_ibus_ack || o_dbus_ack) |-> $past(o_ram_cyc));

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with a behavioural one-cycle-read RAM.
module tb_wb_ram_arbiter;
  logic        clk;
  logic        rst;
  logic [7:0]  ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [7:0]  dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [7:0]  ram_adr;
  logic [31:0] ram_dat;
  logic [3:0]  ram_sel;
  logic        ram_we;
  logic        ram_cyc;
  logic [31:0] ram_rdt;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_dat;

  int n_cmp;
  int n_err;

  wb_ram_arbiter dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_ibus_adr (ibus_adr),
    .i_ibus_cyc (ibus_cyc),
    .o_ibus_rdt (ibus_rdt),
    .o_ibus_ack (ibus_ack),
    .i_dbus_adr (dbus_adr),
    .i_dbus_dat (dbus_dat),
    .i_dbus_sel (dbus_sel),
    .i_dbus_we  (dbus_we),
    .i_dbus_cyc (dbus_cyc),
    .o_dbus_rdt (dbus_rdt),
    .o_dbus_ack (dbus_ack),
    .o_ram_adr  (ram_adr),
    .o_ram_dat  (ram_dat),
    .o_ram_sel  (ram_sel),
    .o_ram_we   (ram_we),
    .o_ram_cyc  (ram_cyc),
    .i_ram_rdt  (ram_rdt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: samples the command on the edge closing the cyc cycle
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_dat;
    end else if (ram_cyc) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_sel[b]) mem[ram_adr[7:2]][8*b +: 8] <= ram_dat[8*b +: 8];
        end
      end
      ram_rdt <= mem[ram_adr[7:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    pre_idx = idx;
    pre_dat = dat;
    pre_we  = 1'b1;
    tick();
    pre_we  = 1'b0;
  endtask

  logic [31:0] b2b_exp [0:3];

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    ibus_adr = '0;
    ibus_cyc = 1'b0;
    dbus_adr = '0;
    dbus_dat = '0;
    dbus_sel = '0;
    dbus_we  = 1'b0;
    dbus_cyc = 1'b0;
    pre_we   = 1'b0;
    pre_idx  = '0;
    pre_dat  = '0;
    ram_rdt  = '0;
    b2b_exp[0] = 32'h1000_0000;
    b2b_exp[1] = 32'h2000_0001;
    b2b_exp[2] = 32'hAA22_AA44;
    b2b_exp[3] = 32'h4000_0003;

    preload(6'd0,  32'h1000_0000);
    preload(6'd1,  32'h2000_0001);
    preload(6'd2,  32'hAAAA_AAAA);
    preload(6'd3,  32'h4000_0003);
    preload(6'h10, 32'hDEAD_BEEF);
    tick();

    chk("rst_ram_cyc", 32'(ram_cyc), 32'd0);
    chk("rst_ram_we",  32'(ram_we), 32'd0);
    chk("rst_ram_sel", 32'(ram_sel), 32'd0);
    chk("rst_ram_adr", 32'(ram_adr), 32'd0);
    chk("rst_ram_dat", ram_dat, 32'd0);
    chk("rst_acks",    {30'd0, ibus_ack, dbus_ack}, 32'd0);
    rst = 1'b0;

    // Single ibus read of word 0x10
    ibus_adr = 8'h40;
    ibus_cyc = 1'b1;
    tick();
    chk("rd_c1_ram_cyc", 32'(ram_cyc), 32'd1);
    chk("rd_c1_ram_adr", 32'(ram_adr), 32'h40);
    chk("rd_c1_ram_sel", 32'(ram_sel), 32'hF);
    chk("rd_c1_ram_we",  32'(ram_we), 32'd0);
    chk("rd_c1_ack",     32'(ibus_ack), 32'd0);
    tick();
    chk("rd_c2_ack",     32'(ibus_ack), 32'd1);
    chk("rd_c2_rdt",     ibus_rdt, 32'hDEAD_BEEF);
    chk("rd_c2_dack",    32'(dbus_ack), 32'd0);
    chk("rd_c2_ram_cyc", 32'(ram_cyc), 32'd0);
    ibus_cyc = 1'b0;
    tick();
    chk("rd_c3_ack",     32'(ibus_ack), 32'd0);

    // Byte-enabled write then read-back
    dbus_adr = 8'h08;
    dbus_dat = 32'h1122_3344;
    dbus_sel = 4'b0101;
    dbus_we  = 1'b1;
    dbus_cyc = 1'b1;
    tick();
    chk("wr_c1_ram_we",  32'(ram_we), 32'd1);
    chk("wr_c1_ram_sel", 32'(ram_sel), 32'h5);
    chk("wr_c1_ram_dat", ram_dat, 32'h1122_3344);
    chk("wr_c1_ram_adr", 32'(ram_adr), 32'h08);
    tick();
    chk("wr_c2_ack",     32'(dbus_ack), 32'd1);
    chk("wr_c2_ram_we",  32'(ram_we), 32'd0);
    dbus_cyc = 1'b0;
    dbus_we  = 1'b0;
    dbus_sel = 4'hF;
    tick();
    dbus_cyc = 1'b1;
    tick();
    tick();
    chk("rb_c2_ack", 32'(dbus_ack), 32'd1);
    chk("rb_c2_rdt", dbus_rdt, 32'hAA22_AA44);
    dbus_cyc = 1'b0;
    tick();

    // Contention straight after reset: ibus first, then alternate
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ibus_adr = 8'h00;
    dbus_adr = 8'h04;
    ibus_cyc = 1'b1;
    dbus_cyc = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("cont_c%0d_iack", c), 32'(ibus_ack), 32'((c == 2) || (c == 8)));
      chk($sformatf("cont_c%0d_dack", c), 32'(dbus_ack), 32'((c == 5) || (c == 11)));
      if (c == 2 || c == 8) chk($sformatf("cont_c%0d_irdt", c), ibus_rdt, 32'h1000_0000);
      if (c == 5 || c == 11) chk($sformatf("cont_c%0d_drdt", c), dbus_rdt, 32'h2000_0001);
    end
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    tick();

    // Back-to-back ibus reads, next cyc raised the cycle after each ack
    for (int i = 0; i < 4; i++) begin
      ibus_adr = 8'(4 * i);
      ibus_cyc = 1'b1;
      tick();
      chk($sformatf("b2b%0d_c1_ack", i), 32'(ibus_ack), 32'd0);
      tick();
      chk($sformatf("b2b%0d_c2_ack", i), 32'(ibus_ack), 32'd1);
      chk($sformatf("b2b%0d_c2_rdt", i), ibus_rdt, b2b_exp[i]);
      ibus_cyc = 1'b0;
      tick();
    end

    // Reset during a dbus write's ACK cycle
    dbus_adr = 8'h10;
    dbus_dat = 32'h0000_0055;
    dbus_sel = 4'hF;
    dbus_we  = 1'b1;
    dbus_cyc = 1'b1;
    tick();
    tick();
    chk("rack_c2_ack", 32'(dbus_ack), 32'd1);
    rst = 1'b1;
    dbus_cyc = 1'b0;
    dbus_we  = 1'b0;
    tick();
    chk("rack_c3_ack",     32'(dbus_ack), 32'd0);
    chk("rack_c3_ram_cyc", 32'(ram_cyc), 32'd0);
    chk("rack_c3_ram_sel", 32'(ram_sel), 32'd0);
    chk("rack_c3_ram_adr", 32'(ram_adr), 32'd0);
    rst = 1'b0;

    // Reset during an ibus ACCESS: no ack, and last_grant must return to dbus
    ibus_adr = 8'h0C;
    ibus_cyc = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("racc_iack",    32'(ibus_ack), 32'd0);
    chk("racc_ram_cyc", 32'(ram_cyc), 32'd0);
    rst = 1'b0;
    dbus_adr = 8'h04;
    dbus_cyc = 1'b1;
    tick();
    chk("post_rst_grant_adr", 32'(ram_adr), 32'h0C);
    tick();
    chk("post_rst_iack", 32'(ibus_ack), 32'd1);
    chk("post_rst_dack", 32'(dbus_ack), 32'd0);
    chk("post_rst_irdt", ibus_rdt, 32'h4000_0003);
    ibus_cyc = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_dack2", 32'(dbus_ack), 32'd1);
    chk("post_rst_drdt",  dbus_rdt, 32'h2000_0001);
    dbus_cyc = 1'b0;
    tick();

    // dbus withdraws cyc during ACCESS
    dbus_adr = 8'h04;
    dbus_cyc = 1'b1;
    tick();
    dbus_cyc = 1'b0;
    tick();
    chk("wd_c2_ack", 32'(dbus_ack), 32'd1);
    chk("wd_c2_rdt", dbus_rdt, 32'h2000_0001);
    tick();
    chk("wd_c3_ack", 32'(dbus_ack), 32'd0);
    chk("wd_c3_ram_cyc", 32'(ram_cyc), 32'd0);
    tick();
    chk("wd_c4_ram_cyc", 32'(ram_cyc), 32'd0);
    chk("wd_c4_ack", 32'(dbus_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
